// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - opcode/funct, ALU, pc_src and state definitions for the multi-cycle RISC controller
package risc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BGEZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // {invA, invB/Cin, op[1:0]}
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_JUMP   = 2'b01;
  localparam logic [1:0] PC_BRANCH = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_RTYPE,
    C_IMM,
    C_BRANCH,
    C_JUMP,
    C_LOAD,
    C_STORE,
    C_ILLEGAL
  } iclass_t;

  function automatic logic is_mem_class(input iclass_t c);
    return (c == C_LOAD) || (c == C_STORE);
  endfunction

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational opcode/funct classifier and ALU operation select
module instr_decode
  import risc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output iclass_t    iclass,
  output logic       half,
  output logic       ovf_checked
);

  always_comb begin
    alu_op      = ALU_ADD;
    iclass      = C_ILLEGAL;
    half        = 1'b0;
    ovf_checked = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        iclass = C_RTYPE;
        case (funct)
          FN_ADD: begin
            alu_op      = ALU_ADD;
            ovf_checked = 1'b1;
          end
          FN_SUB: begin
            alu_op      = ALU_SUB;
            ovf_checked = 1'b1;
          end
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          default: iclass = C_ILLEGAL;
        endcase
      end
      OP_ADDI: begin
        iclass      = C_IMM;
        alu_op      = ALU_ADD;
        ovf_checked = 1'b1;
      end
      // lui reuses the adder; the datapath supplies the shifted immediate
      OP_LUI: begin
        iclass = C_IMM;
        alu_op = ALU_ADD;
      end
      OP_ANDI: begin
        iclass = C_IMM;
        alu_op = ALU_AND;
      end
      OP_ORI: begin
        iclass = C_IMM;
        alu_op = ALU_OR;
      end
      OP_SLTI: begin
        iclass = C_IMM;
        alu_op = ALU_SLT;
      end
      OP_BEQ: begin
        iclass = C_BRANCH;
        alu_op = ALU_SUB;
      end
      OP_BGEZ: begin
        iclass = C_BRANCH;
        alu_op = ALU_ADD;
      end
      OP_J: iclass = C_JUMP;
      OP_LB: iclass = C_LOAD;
      OP_LH: begin
        iclass = C_LOAD;
        half   = 1'b1;
      end
      OP_SB: iclass = C_STORE;
      OP_SH: begin
        iclass = C_STORE;
        half   = 1'b1;
      end
      default: iclass = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory wait timeout and retire counter
module multicycle_ctrl
  import risc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  input  logic             rs_msb,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src,
  output logic [3:0]       alu_op,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic             half,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic             ovf_exc,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_count,
  output logic [2:0]       state_dbg
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MEM_TIMEOUT);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [3:0]        dec_alu_op;
  iclass_t           iclass;
  logic              dec_half;
  logic              ovf_checked;
  logic              limit_hit;
  logic              is_beq;

  instr_decode u_decode (
    .opcode      (opcode),
    .funct       (funct),
    .alu_op      (dec_alu_op),
    .iclass      (iclass),
    .half        (dec_half),
    .ovf_checked (ovf_checked)
  );

  assign limit_hit = (MEM_TIMEOUT != 0) && (wait_cnt == LIMIT);
  assign is_beq    = (opcode == OP_BEQ);
  assign state_dbg = state;

  // The wait counter defaults to clear so that any state change or ready resets it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      instr_count <= '0;
      bus_err     <= 1'b0;
    end else begin
      wait_cnt <= '0;
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (imem_ready) begin
            state <= S_DECODE;
          end else if (limit_hit) begin
            state   <= S_ERR;
            bus_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          case (iclass)
            C_JUMP: begin
              state       <= S_FETCH;
              instr_count <= instr_count + 1'b1;
            end
            C_ILLEGAL: state <= S_FETCH;
            default:   state <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          if (iclass == C_BRANCH) begin
            state       <= S_FETCH;
            instr_count <= instr_count + 1'b1;
          end else if (is_mem_class(iclass)) begin
            state <= S_MEM;
          end else if (ovf_checked && alu_ovf) begin
            state       <= S_FETCH;
            instr_count <= instr_count + 1'b1;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            if (iclass == C_LOAD) begin
              state <= S_WB;
            end else begin
              state       <= S_FETCH;
              instr_count <= instr_count + 1'b1;
            end
          end else if (limit_hit) begin
            state   <= S_ERR;
            bus_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WB: begin
          state       <= S_FETCH;
          instr_count <= instr_count + 1'b1;
        end
        S_ERR:   state <= S_ERR;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SEQ;
    alu_src    = 1'b0;
    alu_op     = ALU_AND;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    half       = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    ovf_exc    = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
        pc_write = imem_ready;
      end
      S_DECODE: begin
        if (iclass == C_JUMP) begin
          pc_write = 1'b1;
          pc_src   = PC_JUMP;
        end
        illegal = (iclass == C_ILLEGAL);
      end
      // PC already holds PC+4 here, so the branch adder sees the right base.
      S_EXEC: begin
        alu_op  = dec_alu_op;
        alu_src = (iclass == C_RTYPE) || is_beq;
        if (iclass == C_BRANCH) begin
          pc_src   = PC_BRANCH;
          pc_write = is_beq ? alu_zero : ~rs_msb;
        end
        ovf_exc = ovf_checked && alu_ovf;
      end
      S_MEM: begin
        dmem_read  = (iclass == C_LOAD);
        dmem_write = (iclass == C_STORE);
        half       = dec_half;
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (iclass == C_RTYPE);
        mem_to_reg = (iclass != C_LOAD);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl against a per-instruction latency/strobe model
module tb_multicycle_ctrl;

  localparam int CNT_W = 4;
  localparam int TMO   = 15;

  logic             clk;
  logic             reset;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             alu_zero;
  logic             alu_ovf;
  logic             rs_msb;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             alu_src;
  logic [3:0]       alu_op;
  logic             dmem_read;
  logic             dmem_write;
  logic             half;
  logic             reg_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             illegal;
  logic             ovf_exc;
  logic             bus_err;
  logic [CNT_W-1:0] instr_count;
  logic [2:0]       state_dbg;

  multicycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .alu_ovf(alu_ovf), .rs_msb(rs_msb),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src(alu_src), .alu_op(alu_op), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .half(half), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal(illegal), .ovf_exc(ovf_exc), .bus_err(bus_err),
    .instr_count(instr_count), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {K_R, K_IMM, K_J, K_BEQ, K_BGEZ, K_LOAD, K_STORE, K_ILL} kind_e;
  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    kind_e      kind;
    logic       ovf;
    logic       hw;
    logic [3:0] aop;
    logic       asrc;
  } instr_t;

  int     checks = 0;
  int     errors = 0;
  int     exp_cnt = 0;
  instr_t tbl[$];

  function automatic instr_t mk(input logic [5:0] op, input logic [5:0] fn, input kind_e kind,
                                input logic ovf, input logic hw, input logic [3:0] aop, input logic asrc);
    instr_t i;
    i.op = op; i.fn = fn; i.kind = kind; i.ovf = ovf; i.hw = hw; i.aop = aop; i.asrc = asrc;
    return i;
  endfunction

  task automatic build_table();
    tbl.push_back(mk(6'b000000, 6'b100000, K_R,     1, 0, 4'b0010, 1));
    tbl.push_back(mk(6'b000000, 6'b100010, K_R,     1, 0, 4'b0110, 1));
    tbl.push_back(mk(6'b000000, 6'b100100, K_R,     0, 0, 4'b0000, 1));
    tbl.push_back(mk(6'b000000, 6'b100101, K_R,     0, 0, 4'b0001, 1));
    tbl.push_back(mk(6'b000000, 6'b100111, K_R,     0, 0, 4'b1100, 1));
    tbl.push_back(mk(6'b000000, 6'b101010, K_R,     0, 0, 4'b0111, 1));
    tbl.push_back(mk(6'b000000, 6'b100011, K_ILL,   0, 0, 4'b0000, 0));
    tbl.push_back(mk(6'b000000, 6'b000000, K_ILL,   0, 0, 4'b0000, 0));
    tbl.push_back(mk(6'b001000, 6'b010101, K_IMM,   1, 0, 4'b0010, 0));
    tbl.push_back(mk(6'b001010, 6'b000000, K_IMM,   0, 0, 4'b0111, 0));
    tbl.push_back(mk(6'b001100, 6'b111111, K_IMM,   0, 0, 4'b0000, 0));
    tbl.push_back(mk(6'b001101, 6'b000000, K_IMM,   0, 0, 4'b0001, 0));
    tbl.push_back(mk(6'b001111, 6'b000000, K_IMM,   0, 0, 4'b0010, 0));
    tbl.push_back(mk(6'b000010, 6'b100000, K_J,     0, 0, 4'b0000, 0));
    tbl.push_back(mk(6'b000100, 6'b000000, K_BEQ,   0, 0, 4'b0110, 1));
    tbl.push_back(mk(6'b000001, 6'b000000, K_BGEZ,  0, 0, 4'b0000, 0));
    tbl.push_back(mk(6'b100000, 6'b000000, K_LOAD,  0, 0, 4'b0010, 0));
    tbl.push_back(mk(6'b100001, 6'b000000, K_LOAD,  0, 1, 4'b0010, 0));
    tbl.push_back(mk(6'b101000, 6'b000000, K_STORE, 0, 0, 4'b0010, 0));
    tbl.push_back(mk(6'b101001, 6'b000000, K_STORE, 0, 1, 4'b0010, 0));
    tbl.push_back(mk(6'b111111, 6'b000000, K_ILL,   0, 0, 4'b0000, 0));
    tbl.push_back(mk(6'b000011, 6'b100000, K_ILL,   0, 0, 4'b0000, 0));
    tbl.push_back(mk(6'b100011, 6'b000000, K_ILL,   0, 0, 4'b0000, 0));
  endtask

  // Called at a falling edge with the DUT in FETCH; returns at the falling edge of the next FETCH.
  task automatic run_instr(input instr_t ins, input int iw, input int dw, input logic az,
                           input logic ao, input logic rm, input string tag);
    int cyc = 0, icnt = 0, dcnt = 0;
    int n_ireq = 0, n_irw = 0, n_pcwf = 0, n_pcwo = 0, n_rw = 0, n_ill = 0, n_ovf = 0;
    int n_rd = 0, n_wr = 0, n_half = 0;
    int e_lat = 0, e_ret = 0, e_pcwo = 0, e_rw = 0, e_ill = 0, e_ovf = 0, e_rd = 0, e_wr = 0, e_half = 0;
    logic [1:0] e_pcs = 2'b00;
    logic [1:0] pcs_o = 2'b00;
    logic [3:0] x_aop = 4'bxxxx;
    logic x_asrc = 1'bx, rdst = 1'bx, m2r = 1'bx, seen_other = 1'b0;
    opcode = ins.op; funct = ins.fn; alu_zero = az; alu_ovf = ao; rs_msb = rm;
    do begin
      if (imem_req) begin imem_ready = (icnt == iw); icnt++; end
      else imem_ready = 1'($urandom_range(0, 1));
      if (dmem_read || dmem_write) begin dmem_ready = (dcnt == dw); dcnt++; end
      else dmem_ready = 1'($urandom_range(0, 1));
      #1;
      if (state_dbg != 3'd1) seen_other = 1'b1;
      if (imem_req) n_ireq++;
      if (ir_write) n_irw++;
      if (pc_write && imem_req) n_pcwf++;
      if (pc_write && !imem_req) begin n_pcwo++; pcs_o = pc_src; end
      if (reg_write) begin n_rw++; rdst = reg_dst; m2r = mem_to_reg; end
      if (illegal) n_ill++;
      if (ovf_exc) n_ovf++;
      if (dmem_read) n_rd++;
      if (dmem_write) n_wr++;
      if (half) n_half++;
      if (state_dbg == 3'd3) begin x_aop = alu_op; x_asrc = alu_src; end
      cyc++;
      @(negedge clk);
    end while (!(seen_other && state_dbg == 3'd1) && cyc < 100);

    case (ins.kind)
      K_J:    begin e_lat = 2; e_ret = 1; e_pcwo = 1; e_pcs = 2'b01; end
      K_ILL:  begin e_lat = 2; e_ill = 1; end
      K_BEQ:  begin e_lat = 3; e_ret = 1; e_pcwo = int'(az); e_pcs = 2'b10; end
      K_BGEZ: begin e_lat = 3; e_ret = 1; e_pcwo = int'(!rm); e_pcs = 2'b10; end
      K_LOAD: begin e_lat = 5 + dw; e_ret = 1; e_rw = 1; e_rd = dw + 1; e_half = ins.hw ? dw + 1 : 0; end
      K_STORE: begin e_lat = 4 + dw; e_ret = 1; e_wr = dw + 1; e_half = ins.hw ? dw + 1 : 0; end
      default: begin
        e_ret = 1;
        if (ins.ovf && ao) begin e_lat = 3; e_ovf = 1; end
        else begin e_lat = 4; e_rw = 1; end
      end
    endcase
    e_lat += iw;
    exp_cnt = (exp_cnt + e_ret) % (1 << CNT_W);

    checks++; if (cyc !== e_lat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", tag, cyc, e_lat); end
    checks++; if (n_ireq !== iw + 1) begin errors++; $display("FAIL %s imem_req cycles: got %0d expected %0d", tag, n_ireq, iw + 1); end
    checks++; if (n_irw !== 1 || n_pcwf !== 1) begin errors++; $display("FAIL %s fetch ir_write/pc_write: got %0d/%0d expected 1/1", tag, n_irw, n_pcwf); end
    checks++; if (n_pcwo !== e_pcwo) begin errors++; $display("FAIL %s pc_write after fetch: got %0d expected %0d", tag, n_pcwo, e_pcwo); end
    if (e_pcwo > 0) begin
      checks++; if (pcs_o !== e_pcs) begin errors++; $display("FAIL %s pc_src: got %b expected %b", tag, pcs_o, e_pcs); end
    end
    checks++; if (n_rw !== e_rw) begin errors++; $display("FAIL %s reg_write cycles: got %0d expected %0d", tag, n_rw, e_rw); end
    if (e_rw > 0) begin
      checks++;
      if (rdst !== (ins.kind == K_R) || m2r !== (ins.kind != K_LOAD)) begin
        errors++; $display("FAIL %s reg_dst/mem_to_reg: got %b/%b expected %b/%b", tag, rdst, m2r, ins.kind == K_R, ins.kind != K_LOAD);
      end
    end
    checks++; if (n_ill !== e_ill || n_ovf !== e_ovf) begin errors++; $display("FAIL %s illegal/ovf_exc pulses: got %0d/%0d expected %0d/%0d", tag, n_ill, n_ovf, e_ill, e_ovf); end
    checks++; if (n_rd !== e_rd || n_wr !== e_wr || n_half !== e_half) begin
      errors++; $display("FAIL %s dmem_read/dmem_write/half cycles: got %0d/%0d/%0d expected %0d/%0d/%0d", tag, n_rd, n_wr, n_half, e_rd, e_wr, e_half);
    end
    if (ins.kind != K_J && ins.kind != K_ILL && ins.kind != K_BGEZ) begin
      checks++; if (x_aop !== ins.aop || x_asrc !== ins.asrc) begin errors++; $display("FAIL %s exec alu_op/alu_src: got %b/%b expected %b/%b", tag, x_aop, x_asrc, ins.aop, ins.asrc); end
    end
    checks++; if (int'(instr_count) !== exp_cnt) begin errors++; $display("FAIL %s instr_count: got %0d expected %0d", tag, instr_count, exp_cnt); end
  endtask

  task automatic test_reset();
    logic [12:0] strobes;
    reset = 1'b1; opcode = 6'd0; funct = 6'd0; alu_zero = 1'b0; alu_ovf = 1'b0; rs_msb = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    repeat (3) @(negedge clk);
    strobes = {imem_req, ir_write, pc_write, alu_src, dmem_read, dmem_write, half,
               reg_write, reg_dst, mem_to_reg, illegal, ovf_exc, bus_err};
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL reset state: got %0d expected 0", state_dbg); end
    checks++; if (strobes !== 13'd0 || pc_src !== 2'b00) begin errors++; $display("FAIL reset strobes: got %b pc_src %b expected all 0", strobes, pc_src); end
    checks++; if (instr_count !== '0) begin errors++; $display("FAIL reset instr_count: got %0d expected 0", instr_count); end
    exp_cnt = 0;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (state_dbg !== 3'd1 || imem_req !== 1'b1) begin errors++; $display("FAIL reset release: got state %0d imem_req %b expected 1/1", state_dbg, imem_req); end
    run_instr(mk(6'b000000, 6'b100000, K_R, 1, 0, 4'b0010, 1), 0, 0, 0, 0, 0, "reset_add");
  endtask

  task automatic test_branch();
    run_instr(mk(6'b000100, 6'b000000, K_BEQ, 0, 0, 4'b0110, 1), 0, 0, 1, 0, 0, "beq_taken");
    run_instr(mk(6'b000100, 6'b000000, K_BEQ, 0, 0, 4'b0110, 1), 0, 0, 0, 0, 0, "beq_not_taken");
    run_instr(mk(6'b000001, 6'b000000, K_BGEZ, 0, 0, 4'b0000, 0), 0, 0, 0, 0, 0, "bgez_taken");
    run_instr(mk(6'b000001, 6'b000000, K_BGEZ, 0, 0, 4'b0000, 0), 0, 0, 0, 0, 1, "bgez_not_taken");
    run_instr(mk(6'b000010, 6'b000000, K_J, 0, 0, 4'b0000, 0), 0, 0, 0, 0, 0, "jump");
  endtask

  task automatic test_load_wait();
    run_instr(mk(6'b100001, 6'b000000, K_LOAD, 0, 1, 4'b0010, 0), 0, 3, 0, 0, 0, "lh_wait3");
    run_instr(mk(6'b101000, 6'b000000, K_STORE, 0, 0, 4'b0010, 0), 2, 1, 0, 0, 0, "sb_wait");
  endtask

  task automatic test_ovf();
    run_instr(mk(6'b001000, 6'b000000, K_IMM, 1, 0, 4'b0010, 0), 0, 0, 0, 1, 0, "addi_ovf");
    run_instr(mk(6'b000000, 6'b100100, K_R, 0, 0, 4'b0000, 1), 0, 0, 0, 1, 0, "and_ovf_ignored");
  endtask

  task automatic test_illegal();
    run_instr(mk(6'b111111, 6'b000000, K_ILL, 0, 0, 4'b0000, 0), 0, 0, 0, 0, 0, "illegal_op");
    run_instr(mk(6'b000000, 6'b100001, K_ILL, 0, 0, 4'b0000, 0), 1, 0, 0, 0, 0, "illegal_funct");
  endtask

  task automatic test_timeout_boundary();
    run_instr(mk(6'b000000, 6'b100101, K_R, 0, 0, 4'b0001, 1), TMO, 0, 0, 0, 0, "imem_ready_at_limit");
    run_instr(mk(6'b100000, 6'b000000, K_LOAD, 0, 0, 4'b0010, 0), 0, TMO, 0, 0, 0, "dmem_ready_at_limit");
  endtask

  task automatic test_timeout();
    int n = 0;
    opcode = 6'b000000; funct = 6'b100000;
    while (state_dbg == 3'd1 && n < 100) begin
      imem_ready = 1'b0;
      @(negedge clk);
      n++;
    end
    checks++; if (n !== TMO + 1) begin errors++; $display("FAIL timeout fetch cycles: got %0d expected %0d", n, TMO + 1); end
    checks++; if (state_dbg !== 3'd6 || bus_err !== 1'b1) begin errors++; $display("FAIL timeout err: got state %0d bus_err %b expected 6/1", state_dbg, bus_err); end
    imem_ready = 1'b1; dmem_ready = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (state_dbg !== 3'd6 || bus_err !== 1'b1 || imem_req !== 1'b0 || pc_write !== 1'b0) begin
      errors++; $display("FAIL err sticky: got state %0d bus_err %b imem_req %b pc_write %b expected 6/1/0/0", state_dbg, bus_err, imem_req, pc_write);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (state_dbg !== 3'd0 || bus_err !== 1'b0 || instr_count !== '0) begin
      errors++; $display("FAIL err reset: got state %0d bus_err %b count %0d expected 0/0/0", state_dbg, bus_err, instr_count);
    end
    exp_cnt = 0;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (state_dbg !== 3'd1) begin errors++; $display("FAIL err resume: got state %0d expected 1", state_dbg); end
  endtask

  task automatic test_reset_mid_mem();
    int n = 0;
    opcode = 6'b100000; funct = 6'd0; imem_ready = 1'b1; dmem_ready = 1'b0;
    while (!dmem_read && n < 20) begin
      @(negedge clk); #1; n++;
    end
    checks++; if (dmem_read !== 1'b1) begin errors++; $display("FAIL mid_mem reach: got dmem_read %b expected 1", dmem_read); end
    reset = 1'b1;
    @(negedge clk); #1;
    checks++; if (dmem_read !== 1'b0 || state_dbg !== 3'd0) begin errors++; $display("FAIL mid_mem reset: got dmem_read %b state %0d expected 0/0", dmem_read, state_dbg); end
    exp_cnt = 0;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (state_dbg !== 3'd1) begin errors++; $display("FAIL mid_mem resume: got state %0d expected 1", state_dbg); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 150; k++) begin
      int idx = $urandom_range(0, tbl.size() - 1);
      int iw = ($urandom_range(0, 9) == 0) ? TMO : $urandom_range(0, 3);
      int dw = $urandom_range(0, 3);
      run_instr(tbl[idx], iw, dw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $sformatf("rand%0d", k));
    end
  endtask

  initial begin
    build_table();
    test_reset();
    test_branch();
    test_load_wait();
    test_ovf();
    test_illegal();
    test_timeout_boundary();
    test_timeout();
    test_reset_mid_mem();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
